// File: rtl/primitive_cycle_sequencer_pkg.sv
// rtl/primitive_cycle_sequencer_pkg.sv - shared sequencer state encoding and parameter defaults
//
// Purpose: state encoding seen on o_STATE and the default slot/flush geometry
// shared by the sequencer top level and anything that decodes its debug state.
package primitive_cycle_sequencer_pkg;

  // Value 3 is never entered; the FSM treats it as a corrupted state.
  typedef enum logic [1:0] {
    SEQ_ALIGN = 2'd0,
    SEQ_FLUSH = 2'd1,
    SEQ_RUN   = 2'd2
  } seq_state_t;

  localparam int SLOTS_DEFAULT        = 32;
  localparam int CYCLE_W_DEFAULT      = 5;
  localparam int FLUSH_ROUNDS_DEFAULT = 2;

endpackage

// File: rtl/primitive_phi1gen.sv
// rtl/primitive_phi1gen.sv - phi1 phase divider producing rising/falling edge enables
//
// Purpose: every sampled master-clock enable toggles the phi1 phase and emits a
// one-EMUCLK active-low enable one cycle later: rising enable on 0->1, falling
// enable on 1->0. Reset clears the phase and cancels any pending pulse.
// Ports:
//   i_EMUCLK       in  sole clock
//   i_RST_n        in  synchronous active-low reset
//   i_MCEN_n       in  master-clock enable, active-low, one EMUCLK wide
//   o_PHI1P_CEN_n  out phi1 rising-edge enable, active-low
//   o_PHI1N_CEN_n  out phi1 falling-edge enable, active-low
module primitive_phi1gen (
  input  logic i_EMUCLK,
  input  logic i_RST_n,
  input  logic i_MCEN_n,
  output logic o_PHI1P_CEN_n,
  output logic o_PHI1N_CEN_n
);

  logic phase;
  logic p_cen_n;
  logic n_cen_n;

  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      phase   <= 1'b0;
      p_cen_n <= 1'b1;
      n_cen_n <= 1'b1;
    end else begin
      // Pulses are single-cycle by construction: default high every edge.
      p_cen_n <= 1'b1;
      n_cen_n <= 1'b1;
      if (!i_MCEN_n) begin
        phase <= ~phase;
        if (!phase) p_cen_n <= 1'b0;
        else        n_cen_n <= 1'b0;
      end
    end
  end

  assign o_PHI1P_CEN_n = p_cen_n;
  assign o_PHI1N_CEN_n = n_cen_n;

endmodule

// File: rtl/primitive_cycle_sequencer.sv
// rtl/primitive_cycle_sequencer.sv - slot counter and align/flush/run sequencer for SR primitives
//
// Purpose: derives phi1 enables, runs the slot counter and sequences power-up
// alignment, zero-fill flushing and normal running of downstream BRAM shift
// registers. Slot-level state only moves on P-edges (EMUCLK edges where
// o_PHI1P_CEN_n is low).
// Ports:
//   i_EMUCLK       in  sole clock
//   i_RST_n        in  synchronous active-low reset
//   i_MCEN_n       in  master-clock enable, active-low
//   i_IC_n         in  runtime initial clear, active-low level
//   o_PHI1P_CEN_n  out phi1 rising-edge enable, active-low
//   o_PHI1N_CEN_n  out phi1 falling-edge enable, active-low
//   o_CYCLE        out current slot number
//   o_SYNC         out high while o_CYCLE == SLOTS-1
//   o_SRRST        out SR counter reset
//   o_SRWR         out SR write enable
//   o_FLUSH        out force SR write data to zero
//   o_STATE        out sequencer state (debug)
module primitive_cycle_sequencer
  import primitive_cycle_sequencer_pkg::*;
#(
  parameter int SLOTS        = SLOTS_DEFAULT,
  parameter int CYCLE_W      = CYCLE_W_DEFAULT,
  parameter int FLUSH_ROUNDS = FLUSH_ROUNDS_DEFAULT
) (
  input  logic               i_EMUCLK,
  input  logic               i_RST_n,
  input  logic               i_MCEN_n,
  input  logic               i_IC_n,
  output logic               o_PHI1P_CEN_n,
  output logic               o_PHI1N_CEN_n,
  output logic [CYCLE_W-1:0] o_CYCLE,
  output logic               o_SYNC,
  output logic               o_SRRST,
  output logic               o_SRWR,
  output logic               o_FLUSH,
  output logic [1:0]         o_STATE
);

  localparam int FC_N = FLUSH_ROUNDS * SLOTS;
  localparam int FC_W = (FC_N > 1) ? $clog2(FC_N) : 1;
  localparam logic [FC_W-1:0]    FC_LAST  = FC_W'(FC_N - 1);
  localparam logic [CYCLE_W-1:0] CYC_LAST = CYCLE_W'(SLOTS - 1);

  logic               p_cen_n;
  logic               pedge;
  seq_state_t         state;
  logic [CYCLE_W-1:0] cycle;
  logic [CYCLE_W-1:0] cycle_next;
  logic [FC_W-1:0]    fc;
  logic               sync;
  logic               srrst;
  logic               srwr;
  logic               flush;

  primitive_phi1gen u_phi1gen (
    .i_EMUCLK      (i_EMUCLK),
    .i_RST_n       (i_RST_n),
    .i_MCEN_n      (i_MCEN_n),
    .o_PHI1P_CEN_n (p_cen_n),
    .o_PHI1N_CEN_n (o_PHI1N_CEN_n)
  );

  assign pedge      = ~p_cen_n;
  assign cycle_next = (cycle == CYC_LAST) ? '0 : cycle + CYCLE_W'(1);

  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      state <= SEQ_ALIGN;
      cycle <= '0;
      sync  <= 1'b0;
      fc    <= '0;
      srrst <= 1'b1;
      srwr  <= 1'b0;
      flush <= 1'b1;
    end else begin
      case (state)
        SEQ_ALIGN: begin
          cycle <= '0;
          sync  <= 1'b0;
          srrst <= 1'b1;
          srwr  <= 1'b0;
          flush <= 1'b1;
          // Downstream counters sample srrst=1 on this same edge, so they
          // and the slot counter both start from zero afterwards.
          if (pedge) begin
            state <= SEQ_FLUSH;
            srrst <= 1'b0;
            srwr  <= 1'b1;
            fc    <= '0;
          end
        end
        SEQ_FLUSH: begin
          srrst <= 1'b0;
          srwr  <= 1'b1;
          if (pedge) begin
            cycle <= cycle_next;
            sync  <= (cycle_next == CYC_LAST);
            if (!i_IC_n) begin
              fc <= '0;
            end else if (fc == FC_LAST) begin
              state <= SEQ_RUN;
              flush <= 1'b0;
            end else if (fc != '1) begin
              fc <= fc + FC_W'(1);
            end
          end
        end
        SEQ_RUN: begin
          srrst <= 1'b0;
          srwr  <= 1'b1;
          if (pedge) begin
            cycle <= cycle_next;
            sync  <= (cycle_next == CYC_LAST);
            // Clear requests only take effect at the round boundary so the
            // flush always covers whole rounds starting at slot 0.
            if (!i_IC_n && cycle == CYC_LAST) begin
              state <= SEQ_FLUSH;
              flush <= 1'b1;
              fc    <= '0;
            end
          end
        end
        default: begin
          state <= SEQ_ALIGN;
          cycle <= '0;
          sync  <= 1'b0;
          fc    <= '0;
          srrst <= 1'b1;
          srwr  <= 1'b0;
          flush <= 1'b1;
        end
      endcase
    end
  end

  assign o_PHI1P_CEN_n = p_cen_n;
  assign o_CYCLE       = cycle;
  assign o_SYNC        = sync;
  assign o_SRRST       = srrst;
  assign o_SRWR        = srwr;
  assign o_FLUSH       = flush;
  assign o_STATE       = state;

endmodule
